// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the multi-cycle RV32 control path:
// opcodes, FSM state encoding, branch_src codes, trap causes and the latched decode record.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_MULDIV = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110
    } branch_src_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_t;

    // jump_src: PC from jump target (jal/jalr); jalr_src: target base is rs1;
    // u_src: U-type immediate path (lui/auipc); uj_src: J-type immediate (jal).
    typedef struct packed {
        logic        alu_src;
        branch_src_t branch_src;
        logic        jump_src;
        logic        jalr_src;
        logic        u_src;
        logic        uj_src;
        logic        is_load;
        logic        is_store;
        logic        is_muldiv;
    } ctrl_fields_t;

    function automatic branch_src_t branch_code(input logic [2:0] funct3);
        branch_src_t code;
        case (funct3)
            3'b000:  code = BR_BEQ;
            3'b001:  code = BR_BNE;
            3'b100:  code = BR_BLT;
            3'b101:  code = BR_BGE;
            3'b110:  code = BR_BLTU;
            3'b111:  code = BR_BGEU;
            default: code = BR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Memory and multiply/divide handshake between the control FSM (master) and the datapath side (slave).
interface mc_control_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        muldiv_start;
    logic        muldiv_done;

    modport master (
        input  instr,
        input  mem_ready,
        input  muldiv_done,
        output mem_req,
        output mem_we,
        output muldiv_start
    );

    modport slave (
        output instr,
        output mem_ready,
        output muldiv_done,
        input  mem_req,
        input  mem_we,
        input  muldiv_start
    );
endinterface

// File: rtl/instr_decode.sv
// Combinational instruction decode: instr -> control fields plus legal flag.
// RV_MEXT_EN makes R-type funct7=0000001 a legal multiply/divide op.
module instr_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_fields_t fields,
    output logic         legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    // register indices and immediates belong to the datapath
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        fields = '0;
        legal  = 1'b1;
        case (opcode)
            OP_R: begin
`ifdef RV_MEXT_EN
                fields.is_muldiv = (funct7 == F7_MULDIV);
`else
                legal = (funct7 != F7_MULDIV);
`endif
            end
            OP_IMM: begin
                fields.alu_src = 1'b1;
            end
            OP_LOAD: begin
                fields.alu_src = 1'b1;
                fields.is_load = 1'b1;
            end
            OP_STORE: begin
                fields.alu_src  = 1'b1;
                fields.is_store = 1'b1;
            end
            OP_BRANCH: begin
                fields.branch_src = branch_code(funct3);
                legal             = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OP_JALR: begin
                fields.alu_src  = 1'b1;
                fields.jump_src = 1'b1;
                fields.jalr_src = 1'b1;
            end
            OP_JAL: begin
                fields.jump_src = 1'b1;
                fields.uj_src   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                fields.alu_src = 1'b1;
                fields.u_src   = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM: fetch, decode, execute, memory access, writeback, trap.
// Define RV_MEXT_EN to accept multiply/divide ops through the MULDIV state.
//
// state  | meaning
// FETCH  | instruction read outstanding, IR loads on mem_ready
// DECODE | instr decoded, control fields latched
// EXEC   | ALU cycle, branches resolve and update PC
// MEM    | load/store access outstanding
// MULDIV | waiting for multiply/divide result
// WB     | register writeback and PC update
// TRAP   | fault parked until reset
module mc_control
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic         clk,
    input  logic         rst,
    mc_control_if.master bus,
    output logic         pc_write,
    output logic         ir_write,
    output logic         reg_write,
    output logic         mem_to_reg,
    output logic         alu_src,
    output logic [2:0]   branch_src,
    output logic         jump_src,
    output logic         jalr_src,
    output logic         u_src,
    output logic         uj_src,
    output logic         busy,
    output logic         trap,
    output logic [1:0]   trap_cause
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    ctrl_fields_t     fields_q, fields_d;
    trap_cause_t      cause_q, cause_d;

    ctrl_fields_t     dec_fields;
    logic             dec_legal;
    logic             wait_last;
    logic             sel_en;
    logic             pc_write_c;
    logic             ir_write_c;
    logic             reg_write_c;
    logic             mem_to_reg_c;
    logic             mem_req_c;
    logic             mem_we_c;
`ifdef RV_MEXT_EN
    logic             muldiv_start_c;
`endif

    instr_decode u_decode (
        .instr  (bus.instr),
        .fields (dec_fields),
        .legal  (dec_legal)
    );

    // last permitted wait cycle: a ready here still completes
    assign wait_last = (wait_cnt_q == CNT_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            fields_q   <= '0;
            cause_q    <= CAUSE_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fields_q   <= fields_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = '0;
        fields_d     = fields_q;
        cause_d      = cause_q;
        sel_en       = 1'b0;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        mem_to_reg_c = 1'b0;
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
`ifdef RV_MEXT_EN
        muldiv_start_c = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wait_last) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_DECODE: begin
                fields_d = dec_fields;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                sel_en = 1'b1;
                if (fields_q.is_load || fields_q.is_store) begin
                    state_d = ST_MEM;
                end else if (fields_q.branch_src != BR_NONE) begin
                    pc_write_c = 1'b1;
                    state_d    = ST_FETCH;
`ifdef RV_MEXT_EN
                end else if (fields_q.is_muldiv) begin
                    muldiv_start_c = 1'b1;
                    state_d        = ST_MULDIV;
`endif
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                sel_en    = 1'b1;
                mem_req_c = 1'b1;
                mem_we_c  = fields_q.is_store;
                if (bus.mem_ready) begin
                    if (fields_q.is_store) begin
                        pc_write_c = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_last) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
`ifdef RV_MEXT_EN
            ST_MULDIV: begin
                sel_en = 1'b1;
                if (bus.muldiv_done) begin
                    state_d = ST_WB;
                end
            end
`endif
            ST_WB: begin
                sel_en       = 1'b1;
                reg_write_c  = 1'b1;
                pc_write_c   = 1'b1;
                mem_to_reg_c = fields_q.is_load;
                state_d      = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // reset forces every output low regardless of the registered state
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        branch_src  = 3'b000;
        jump_src    = 1'b0;
        jalr_src    = 1'b0;
        u_src       = 1'b0;
        uj_src      = 1'b0;
        busy        = 1'b0;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
`ifdef RV_MEXT_EN
        bus.muldiv_start = 1'b0;
`endif
        if (!rst) begin
            pc_write    = pc_write_c;
            ir_write    = ir_write_c;
            reg_write   = reg_write_c;
            mem_to_reg  = mem_to_reg_c;
            bus.mem_req = mem_req_c;
            bus.mem_we  = mem_we_c;
`ifdef RV_MEXT_EN
            bus.muldiv_start = muldiv_start_c;
`endif
            busy        = (state_q != ST_TRAP);
            trap        = (state_q == ST_TRAP);
            trap_cause  = cause_q;
            if (sel_en) begin
                alu_src    = fields_q.alu_src;
                branch_src = fields_q.branch_src;
                jump_src   = fields_q.jump_src;
                jalr_src   = fields_q.jalr_src;
                u_src      = fields_q.u_src;
                uj_src     = fields_q.uj_src;
            end
        end
    end

`ifndef RV_MEXT_EN
    logic unused_mext;
    assign bus.muldiv_start = 1'b0;
    assign unused_mext      = bus.muldiv_done ^ fields_q.is_muldiv;
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-instruction expected output traces are built up front
// from the instruction's class and handshake delays, then replayed and compared every cycle.
module tb_mc_control;

    localparam int WAIT = 15;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [2:0] branch_src;
        logic       jump_src;
        logic       jalr_src;
        logic       u_src;
        logic       uj_src;
        logic       muldiv_start;
        logic       busy;
        logic       trap;
        logic [1:0] cause;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        done;
        logic [31:0] instr;
        out_t        exp;
    } cyc_t;

    logic       clk;
    logic       rst;
    logic       pc_write, ir_write, reg_write, mem_to_reg, alu_src;
    logic [2:0] branch_src;
    logic       jump_src, jalr_src, u_src, uj_src;
    logic       busy, trap;
    logic [1:0] trap_cause;
    out_t       act;

    mc_control_if bus();

    mc_control #(.MEM_WAIT_MAX(WAIT), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .branch_src (branch_src),
        .jump_src   (jump_src),
        .jalr_src   (jalr_src),
        .u_src      (u_src),
        .uj_src     (uj_src),
        .busy       (busy),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    assign act = {pc_write, ir_write, bus.mem_req, bus.mem_we, reg_write, mem_to_reg, alu_src,
                  branch_src, jump_src, jalr_src, u_src, uj_src, bus.muldiv_start, busy, trap,
                  trap_cause};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cyc_t q[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   retired = 0;

    task automatic check(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, want);
    endtask

    task automatic push(input logic r, input logic rdy, input logic done, input logic [31:0] ins,
                        input out_t e);
        cyc_t c;
        c.rst = r; c.rdy = rdy; c.done = done; c.instr = ins; c.exp = e;
        q.push_back(c);
    endtask

    task automatic do_reset(input int n, input logic rdy);
        for (int i = 0; i < n; i++) push(1'b1, rdy, 1'b0, 32'h0, '0);
    endtask

    task automatic trap_run(input logic [31:0] ins, input logic [1:0] cause);
        out_t e;
        e = '0; e.trap = 1'b1; e.cause = cause;
        for (int i = 0; i < 4; i++) push(1'b0, i[0], i[1], ins, e);
    endtask

    // Instruction class and the selects it must present while executing
    function automatic void classify(input logic [31:0] ins, output out_t s, output bit ld,
                                     output bit st, output bit br, output bit mul, output bit legal);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        s = '0; ld = 0; st = 0; br = 0; mul = 0; legal = 1;
        case (op)
            7'b0110011: begin
                if (f7 == 7'b0000001) begin
`ifdef RV_MEXT_EN
                    mul = 1;
`else
                    legal = 0;
`endif
                end
            end
            7'b0010011: s.alu_src = 1;
            7'b0000011: begin s.alu_src = 1; ld = 1; end
            7'b0100011: begin s.alu_src = 1; st = 1; end
            7'b1100111: begin s.alu_src = 1; s.jump_src = 1; s.jalr_src = 1; end
            7'b1101111: begin s.jump_src = 1; s.uj_src = 1; end
            7'b0110111, 7'b0010111: begin s.alu_src = 1; s.u_src = 1; end
            7'b1100011: begin
                br = 1;
                case (f3)
                    3'b000:  s.branch_src = 3'b001;
                    3'b001:  s.branch_src = 3'b010;
                    3'b100:  s.branch_src = 3'b011;
                    3'b101:  s.branch_src = 3'b100;
                    3'b110:  s.branch_src = 3'b101;
                    3'b111:  s.branch_src = 3'b110;
                    default: legal = 0;
                endcase
            end
            default: legal = 0;
        endcase
    endfunction

    // fw/mw: not-ready cycles before ready in fetch/memory; md: not-done cycles in muldiv;
    // noise: drive mem_ready high where it must be ignored; abort: stop after that many memory waits
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int md,
                             input bit noise, input int abort);
        out_t s, e;
        bit   ld, st, br, mul, legal;
        classify(ins, s, ld, st, br, mul, legal);
        for (int i = 0; i < fw && i < WAIT; i++) begin
            e = '0; e.mem_req = 1; e.busy = 1; push(0, 0, 0, ins, e);
        end
        if (fw >= WAIT) begin trap_run(ins, 2'b10); return; end
        e = '0; e.mem_req = 1; e.ir_write = 1; e.busy = 1; push(0, 1, 0, ins, e);
        e = '0; e.busy = 1; push(0, noise, 0, ins, e);
        if (!legal) begin trap_run(ins, 2'b01); return; end
        e = s; e.busy = 1; e.pc_write = br; e.muldiv_start = mul; push(0, noise, 0, ins, e);
        if (br) begin retired++; return; end
        if (ld || st) begin
            for (int i = 0; i < mw && i < WAIT; i++) begin
                if (i == abort) return;
                e = s; e.mem_req = 1; e.mem_we = st; e.busy = 1; push(0, 0, 0, ins, e);
            end
            if (mw >= WAIT) begin trap_run(ins, 2'b10); return; end
            e = s; e.mem_req = 1; e.mem_we = st; e.busy = 1; e.pc_write = st; push(0, 1, 0, ins, e);
            if (st) begin retired++; return; end
        end
        if (mul) begin
            for (int i = 0; i < md; i++) begin e = s; e.busy = 1; push(0, noise, 0, ins, e); end
            e = s; e.busy = 1; push(0, noise, 1, ins, e);
        end
        e = s; e.busy = 1; e.reg_write = 1; e.pc_write = 1; e.mem_to_reg = ld; push(0, noise, 0, ins, e);
        retired++;
    endtask

    initial begin
        cyc_t c;
        int   n0;
        int   cyc = 0;
        int   dut_pcw = 0, dut_rw = 0, dut_ms = 0, dut_m2r = 0;

        rst = 1'b1; bus.instr = 32'h0; bus.mem_ready = 1'b0; bus.muldiv_done = 1'b0;

        do_reset(3, 1'b0);
        n0 = q.size(); run_instr(32'h00500093, 0, 0, 0, 0, -1);
        check("addi_trace_len", q.size() - n0, 4);
        n0 = q.size(); run_instr(32'h0000A103, 2, 3, 0, 1, -1);
        check("lw_trace_len", q.size() - n0, 10);
        n0 = q.size(); run_instr(32'h00208463, 1, 0, 0, 1, -1);
        check("beq_trace_len", q.size() - n0, 4);
        run_instr(32'h0020A223, 0, 14, 0, 0, -1);
        run_instr(32'h00209463, 0, 0, 0, 0, -1);
        run_instr(32'h0020F463, 0, 0, 0, 1, -1);
        run_instr(32'h010000EF, 0, 0, 0, 0, -1);
        run_instr(32'h123452B7, 1, 0, 0, 0, -1);
        run_instr(32'h00008067, 0, 0, 0, 1, -1);
        run_instr(32'h00000297, 0, 0, 0, 0, -1);
        run_instr(32'h002081B3, 0, 0, 0, 0, -1);
        run_instr(32'h00500093, 14, 0, 0, 0, -1);
        run_instr(32'h02208033, 0, 0, 4, 1, -1);
        do_reset(2, 1'b1);
        run_instr(32'h00000000, 0, 0, 0, 0, -1);
        do_reset(2, 1'b0);
        run_instr(32'h0020A463, 0, 0, 0, 0, -1);
        do_reset(2, 1'b0);
        run_instr(32'h00500093, 15, 0, 0, 0, -1);
        do_reset(2, 1'b0);
        run_instr(32'h0000A103, 0, 15, 0, 0, -1);
        do_reset(2, 1'b0);
        run_instr(32'h0000A103, 0, 10, 0, 0, 2);
        do_reset(2, 1'b1);
        run_instr(32'h00500093, 0, 0, 0, 0, -1);

        while (q.size() > 0) begin
            @(posedge clk);
            #1;
            c = q.pop_front();
            rst             = c.rst;
            bus.mem_ready   = c.rdy;
            bus.muldiv_done = c.done;
            bus.instr       = c.instr;
            @(negedge clk);
            n_total++;
            if (act === c.exp) n_pass++;
            else $display("FAIL cycle_outputs @%0d (instr %h rst %0d): got %b, expected %b",
                          cyc, c.instr, c.rst, act, c.exp);
            dut_pcw += int'(pc_write);
            dut_rw  += int'(reg_write);
            dut_ms  += int'(bus.muldiv_start);
            dut_m2r += int'(mem_to_reg);
            cyc++;
        end

        check("pc_write_vs_retired", dut_pcw, retired);
`ifdef RV_MEXT_EN
        check("pc_write_pulses", dut_pcw, 14);
        check("reg_write_pulses", dut_rw, 10);
        check("muldiv_start_pulses", dut_ms, 1);
`else
        check("pc_write_pulses", dut_pcw, 13);
        check("reg_write_pulses", dut_rw, 9);
        check("muldiv_start_pulses", dut_ms, 0);
`endif
        check("mem_to_reg_pulses", dut_m2r, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, max wait cycles per memory request before timeout trap.
REQ-002 SHALL have parameter CNT_W, default 4, width of wait counter; MEM_WAIT_MAX < 2**CNT_W.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents
- mem_ready  in  1  memory completes current request this cycle
- muldiv_done  in  1  multiply/divide unit result valid
- pc_write  out  1  PC update strobe
- ir_write  out  1  instruction register load strobe
- mem_req  out  1  memory request active
- mem_we  out  1  request is a store
- reg_write  out  1  register file write strobe
- mem_to_reg  out  1  writeback selects load data
- alu_src  out  1  ALU B operand is immediate
- branch_src  out  3  000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu
- jump_src, jalr_src, u_src, uj_src  out  1 each  PC/ALU-A/writeback selects
- muldiv_start  out  1  one-cycle start pulse
- busy  out  1  high in every state except TRAP
- trap  out  1  sticky fault indication
- trap_cause  out  2  00 none, 01 illegal, 10 timeout

Function
REQ-004 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, MULDIV, WB, TRAP.
REQ-005 FETCH: mem_req=1, mem_we=0; on mem_ready, ir_write=1 for that cycle, next DECODE.
REQ-006 DECODE: exactly 1 cycle; latch decoded fields from instr; legal opcode -> EXEC, else -> TRAP with cause 01.
REQ-007 Legal opcodes: 0110011, 0010011, 0000011, 1100111 (jalr), 0100011, 1100011, 0110111, 0010111, 1101111; branch funct3 010/011 is illegal.
REQ-008 EXEC: 1 cycle; load/store -> MEM; branch -> FETCH with pc_write=1; all others -> WB.
REQ-009 MEM: mem_req=1, mem_we=1 for store; on mem_ready, load -> WB, store -> FETCH with pc_write=1.
REQ-010 WB: 1 cycle; reg_write=1, pc_write=1, mem_to_reg=1 for loads only; next FETCH.
REQ-011 pc_write SHALL assert exactly once per retired instruction; reg_write only in WB.
REQ-012 Decoded selects (alu_src, branch_src, jump_src, jalr_src, u_src, uj_src) SHALL be driven from latched fields, stable EXEC through WB; 0 in FETCH/DECODE/TRAP.
REQ-013 Wait counter SHALL clear on entering FETCH or MEM, increment each cycle mem_ready=0; reaching MEM_WAIT_MAX without mem_ready -> TRAP, cause 10.
REQ-014 mem_ready on the cycle the counter reaches MEM_WAIT_MAX SHALL complete normally (ready wins).
REQ-015 TRAP: all strobes 0, busy=0, trap=1; exit only via rst.
REQ-016 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-017 While rst=1 all outputs SHALL be 0; state, counter, latched fields and trap_cause cleared.
REQ-018 First cycle after rst falls: state FETCH, mem_req=1, busy=1.
REQ-019 rst mid-request SHALL abandon the request without pc_write/reg_write.

Configuration
REQ-020 With RV_MEXT_EN defined: opcode 0110011 funct7 0000001 is legal; EXEC pulses muldiv_start, -> MULDIV; MULDIV holds until muldiv_done, then WB.
REQ-021 Without RV_MEXT_EN: funct7 0000001 with opcode 0110011 is illegal (cause 01); MULDIV state, muldiv_start logic absent, muldiv_start tied 0.

Structure
REQ-022 Package rv_ctrl_pkg SHALL hold opcode constants, state encoding, branch_src codes, trap_cause codes.
REQ-023 Sub-module instr_decode (combinational instr -> control fields + legal flag) SHALL be instantiated once.

Verification
REQ-024 addi x1,x0,5 (0x00500093), mem_ready on 1st FETCH cycle -> FETCH,DECODE,EXEC,WB; reg_write=1, alu_src=1 in WB; 4 cycles.
REQ-025 lw, mem_ready delayed 3 cycles in MEM -> mem_to_reg=1, reg_write=1 in WB; pc_write exactly once.
REQ-026 beq (funct3 000) -> branch_src=001 in EXEC, pc_write=1 there, no reg_write, back to FETCH.
REQ-027 instr=0x00000000 -> TRAP after DECODE, trap=1, trap_cause=01, busy=0 until rst.
REQ-028 mem_ready held 0 in FETCH, MEM_WAIT_MAX=15 -> TRAP cause 10 after 15 wait cycles; ready on 15th cycle -> DECODE.
REQ-029 RV_MEXT_EN, mul (0x02208033), muldiv_done after 5 cycles -> muldiv_start one pulse, WB after done; without macro -> trap cause 01.
